alu_instr_sequencer: RTL and testbench
======================================

# alu_instr_sequencer

Hardwired control sequencer for the register-to-register ALU instruction class of the simple CPU datapath. It replaces hand-driven control strobes with an FSM that runs the T0–T6 micro-step sequence: fetch through PC/MAR/MDR/IR, operand moves through Y, and result write-back from Z to a general register or HI/LO. It sits between the memory interface and the datapath and owns every bus-drive and register-enable strobe for these instructions.

## Interface
- No parameters. Opcodes and field positions are fixed constants in the shared package.
- Clock  in  1  system clock; all state changes on rising edge.
- Clear  in  1  synchronous, active-high reset.
- Start  in  1  begin one instruction when in IDLE; ignored elsewhere.
- MemReady  in  1  memory read data valid on Mdatain; sampled in T1.
- IR  in  32  instruction register contents (datapath IR output).
- PCout, MDRout, Zlowout, ZHighout  out  1 each  bus-drive strobes.
- MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin  out  1 each  register enables.
- IncPC, Read  out  1 each  PC increment, memory read.
- Rout  out  16  one-hot general-register bus drive (R0..R15).
- Rin  out  16  one-hot general-register load enable.
- operation  out  5  ALU operation code.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on completion.
- Illegal  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- IR fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- Supported opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, MUL 01111, DIV 10000.
- operation = opcode in T4. The ALU uses the same encoding. operation = 0 in all other states.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, ILL.
- IDLE: all outputs 0. Start=1 → T0.
- T0: PCout, MARin, IncPC, Zin → T1.
- T1: Zlowout, PCin, Read, MDRin. If MemReady=0, stay in T1 and hold the strobes; PCin pulses only on the first T1 cycle. If MemReady=1 → T2.
- T2: MDRout, IRin → T3.
- T3: decode the opcode from IR. Unsupported opcode → ILL with no strobes asserted. Otherwise Rout[Rb], Yin → T4.
- T4: Rout[Rc], operation, Zin → T5.
- T5: Zlowout plus a load enable. For MUL/DIV the enable is LOin, then → T6. For all other opcodes it is Rin[Ra], then → DONE.
- T6 (MUL/DIV only): ZHighout, HIin → DONE.
- DONE: Done=1 → IDLE.
- ILL: Illegal=1 → IDLE.
- Rout and Rin are each one-hot or zero, and never both nonzero in the same cycle.
- At most one bus-drive strobe (PCout, MDRout, Zlowout, ZHighout, any Rout bit) is high in any cycle.

## Timing
- Moore outputs, decoded combinationally from the registered state. No output depends on Start or MemReady in the same cycle, except that the T1 exit waits on MemReady.
- Clear has priority over all inputs. It forces IDLE on the next edge from any state, including mid-instruction and during the T1 wait. After Clear, all outputs are 0 and Busy=0.
- Latency from the Start edge, with MemReady=1 in the first T1 cycle:
  - Non-MUL/DIV: Done is high in cycle 7 (T0..T5, then DONE).
  - MUL/DIV: Done is high in cycle 8.
  - Each MemReady=0 cycle in T1 adds one cycle.
- Start held high through DONE: IDLE re-enters, and the next instruction begins one cycle later. There is no back-to-back issue from DONE.
- Start asserted while Busy=1 is ignored and is not queued.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode localparams;
  - IR field bit positions;
  - the state enum/localparams, shared with the future load/store/branch sequencers.
- One sub-module, reg_select_decoder. It converts a 4-bit register index plus an enable into a 16-bit one-hot vector, and is instantiated once for Rout and once for Rin.

## Test plan
- ROL R4,R3,R7: IR=0x421B8000, MemReady=1 → T3 Rout=0x0008, T4 Rout=0x0080 with operation=01000, T5 Rin=0x0010, Done in cycle 7.
- AND R4,R3,R7: IR=0x2A1B8000, MemReady low for 3 cycles in T1 → T1 lasts 4 cycles, PCin high only in the first, Done in cycle 10.
- MUL R3,R7: IR=0x781B8000 → T5 Zlowout+LOin, T6 ZHighout+HIin, Rin=0 throughout, Done in cycle 8.
- Opcode 11111 → Illegal pulse one cycle after T3, no Yin/Zin/Rin activity, then IDLE.
- Clear asserted in T4 → next cycle IDLE with all outputs 0. A following Start runs a clean full sequence.
- Every cycle of every run: at most one bus driver high, and Rout/Rin one-hot-or-zero (assertion checks).

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, IR field positions and sequencer states
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef enum logic [3:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_DONE, ST_ILL
    } ctrl_state_t;

    function automatic logic op_supported(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL, OP_MUL, OP_DIV: op_supported = 1'b1;
            default:                                 op_supported = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_muldiv(input logic [4:0] op);
        op_is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - 4-bit register index to 16-bit one-hot select
module reg_select_decoder (
    input  logic [3:0]  index,
    input  logic        enable,
    output logic [15:0] onehot
);

    assign onehot = enable ? (16'd1 << index) : 16'd0;

endmodule

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - T0..T6 control sequencer for reg-to-reg ALU instructions
module alu_instr_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Start,
    input  logic        MemReady,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        LOin,
    output logic        HIin,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [4:0]  operation,
    output logic        Busy,
    output logic        Done,
    output logic        Illegal
);

    ctrl_state_t state;
    logic        t1_held;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       legal, muldiv;
    logic       unused_ir_bits;

    assign opcode = IR[OPC_HI:OPC_LO];
    assign ra     = IR[RA_HI:RA_LO];
    assign rb     = IR[RB_HI:RB_LO];
    assign rc     = IR[RC_HI:RC_LO];
    assign legal  = op_supported(opcode);
    assign muldiv = op_is_muldiv(opcode);
    assign unused_ir_bits = ^IR[14:0];

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state   <= ST_IDLE;
            t1_held <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (Start) state <= ST_T0;
                ST_T0:   state <= ST_T1;
                ST_T1:   if (MemReady) state <= ST_T2;
                ST_T2:   state <= ST_T3;
                ST_T3:   state <= legal ? ST_T4 : ST_ILL;
                ST_T4:   state <= ST_T5;
                ST_T5:   state <= muldiv ? ST_T6 : ST_DONE;
                ST_T6:   state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
            // Marks T1 repeat cycles so PC is loaded only once per fetch.
            t1_held <= (state == ST_T1) && !MemReady;
        end
    end

    logic       rout_en, rin_en;
    logic [3:0] rout_idx;

    assign rout_en  = ((state == ST_T3) && legal) || (state == ST_T4);
    assign rout_idx = (state == ST_T4) ? rc : rb;
    assign rin_en   = (state == ST_T5) && !muldiv;

    reg_select_decoder u_rout_dec (.index(rout_idx), .enable(rout_en), .onehot(Rout));
    reg_select_decoder u_rin_dec  (.index(ra),       .enable(rin_en),  .onehot(Rin));

    always_comb begin
        PCout = 1'b0; MDRout = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0;
        MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; LOin = 1'b0; HIin = 1'b0;
        IncPC = 1'b0; Read = 1'b0; operation = 5'd0;
        Done = 1'b0; Illegal = 1'b0;
        Busy = (state != ST_IDLE);
        case (state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = !t1_held; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: Yin = legal;
            ST_T4: begin operation = opcode; Zin = 1'b1; end
            ST_T5: begin Zlowout = 1'b1; LOin = muldiv; end
            ST_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
            ST_DONE: Done = 1'b1;
            ST_ILL:  Illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - scoreboard bench for alu_instr_sequencer
module tb_alu_instr_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Start = 1'b0;
    logic        MemReady = 1'b0;
    logic [31:0] IR = 32'd0;
    logic PCout, MDRout, Zlowout, ZHighout, MARin, PCin, MDRin, IRin;
    logic Yin, Zin, LOin, HIin, IncPC, Read, Busy, Done, Illegal;
    logic [15:0] Rout, Rin;
    logic [4:0]  operation;

    alu_instr_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(IR),
        .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .ZHighout(ZHighout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin),
        .operation(operation), .Busy(Busy), .Done(Done), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic pcout, mdrout, zlowout, zhighout, marin, pcin, mdrin, irin;
        logic yin, zin, loin, hiin, incpc, read;
        logic [15:0] rout, rin;
        logic [4:0]  operation;
        logic busy, done, illegal;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   step = 0;
    bit   monitor_on = 0;

    logic [4:0] legal_ops [11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                   5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000};

    function automatic bit is_legal(input logic [4:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected per-cycle outputs for one instruction, starting at the IDLE cycle where Start is seen.
    function automatic void build_plan(input logic [31:0] ir, input int waits, input bit cut_t4,
                                       ref obs_t plan[$]);
        logic [4:0] op = ir[31:27];
        logic [3:0] ra = ir[26:23];
        logic [3:0] rb = ir[22:19];
        logic [3:0] rc = ir[18:15];
        bit md = (op == 5'b01111) || (op == 5'b10000);
        obs_t r;
        plan.delete();
        r = '0; plan.push_back(r);
        r = '0; r.busy = 1; r.pcout = 1; r.marin = 1; r.incpc = 1; r.zin = 1; plan.push_back(r);
        for (int w = 0; w <= waits; w++) begin
            r = '0; r.busy = 1; r.zlowout = 1; r.read = 1; r.mdrin = 1; r.pcin = (w == 0);
            plan.push_back(r);
        end
        r = '0; r.busy = 1; r.mdrout = 1; r.irin = 1; plan.push_back(r);
        if (!is_legal(op)) begin
            r = '0; r.busy = 1; plan.push_back(r);
            r = '0; r.busy = 1; r.illegal = 1; plan.push_back(r);
            return;
        end
        r = '0; r.busy = 1; r.rout = 16'd1 << rb; r.yin = 1; plan.push_back(r);
        r = '0; r.busy = 1; r.rout = 16'd1 << rc; r.operation = op; r.zin = 1; plan.push_back(r);
        if (cut_t4) begin
            r = '0; plan.push_back(r);
            return;
        end
        r = '0; r.busy = 1; r.zlowout = 1;
        if (md) r.loin = 1; else r.rin = 16'd1 << ra;
        plan.push_back(r);
        if (md) begin
            r = '0; r.busy = 1; r.zhighout = 1; r.hiin = 1; plan.push_back(r);
        end
        r = '0; r.busy = 1; r.done = 1; plan.push_back(r);
    endfunction

    // Entered and left at posedge+1; drives one planned cycle per clock.
    task automatic run(input logic [31:0] ir, input int waits, input bit cut_t4);
        obs_t plan[$];
        int n;
        build_plan(ir, waits, cut_t4, plan);
        n = plan.size();
        foreach (plan[k]) exp_q.push_back(plan[k]);
        for (int i = 0; i < n; i++) begin
            IR = ir;
            if (i == 0) Start = 1'b1;
            else if (i == n - 1) Start = 1'b0;
            else Start = 1'($urandom_range(0, 1));
            if (i >= 2 && i < 2 + waits) MemReady = 1'b0;
            else if (i == 2 + waits) MemReady = 1'b1;
            else MemReady = 1'($urandom_range(0, 1));
            Clear = cut_t4 && (i == waits + 5);
            @(posedge Clock); #1;
        end
        Clear = 1'b0;
        Start = 1'b0;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] op;
        if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 10)];
        else op = 5'($urandom);
        return {op, 27'($urandom)};
    endfunction

    always @(negedge Clock) begin
        if (monitor_on) begin
            int drivers;
            drivers = int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(ZHighout) + $countones(Rout);
            n_checks++;
            if (drivers > 1 || $countones(Rout) > 1 || $countones(Rin) > 1 || (Rout != 0 && Rin != 0)) begin
                n_fail++;
                $display("FAIL bus_onehot step%0d drivers=%0d rout=%h rin=%h required <=1 driver, one-hot-or-zero",
                         step, drivers, Rout, Rin);
            end
            if (exp_q.size() > 0) begin
                obs_t e, g;
                e = exp_q.pop_front();
                g = '{PCout, MDRout, Zlowout, ZHighout, MARin, PCin, MDRin, IRin, Yin, Zin, LOin,
                      HIin, IncPC, Read, Rout, Rin, operation, Busy, Done, Illegal};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs step%0d got=%h exp=%h", step, g, e);
                end
            end
            step++;
        end
    end

    initial begin
        obs_t z;
        Clear = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        monitor_on = 1;
        z = '0;
        exp_q.push_back(z);
        Clear = 1'b0;
        @(posedge Clock); #1;
        run(32'h421B8000, 0, 0);
        run(32'h2A1B8000, 3, 0);
        run(32'h781B8000, 0, 0);
        run({5'b11111, 27'($urandom)}, $urandom_range(0, 2), 0);
        run(32'h1A1B8000, 1, 1);
        run(32'h1A1B8000, 0, 0);
        run(32'h801B8000, 2, 0);
        for (int t = 0; t < 60; t++) begin
            int gap;
            run(rand_ir(), $urandom_range(0, 3), 0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                exp_q.push_back(z);
                @(posedge Clock); #1;
            end
        end
        for (int b = 0; b < 50 && exp_q.size() > 0; b++) @(posedge Clock);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        @(posedge Clock); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
